// File: rtl/uart_pkg.sv
// Shared state encoding and frame-geometry helpers for the UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   function automatic int frame_bits(input int data_w, input int parity_en, input int stop_bits);
      return 1 + data_w + parity_en + stop_bits;
   endfunction

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_piso_tx_if.sv
// Producer-side handshake plus serial line and status for the UART transmitter.
interface uart_piso_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              serial_out;
   logic              tx_busy;
   logic              tx_done;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, serial_out, tx_busy, tx_done
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, serial_out, tx_busy, tx_done
   );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 while enabled, strobes o_bit_end on the last cycle.
// Held at zero while disabled; i_restart realigns the count when a new frame loads.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic i_clk,
   input  logic i_clr_n,
   input  logic i_en,
   input  logic i_restart,
   output logic o_bit_end
);
   localparam int            CW   = cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_cnt <= '0;
      end else if (i_restart || !i_en || o_bit_end) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_bit_end = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_piso_tx.sv
// Parallel-in/serial-out UART transmitter with a one-word holding buffer for back-to-back frames.
// Outputs are registered one cycle behind the FSM; TX_READY is low while the holding buffer is full.
module uart_piso_tx
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int LSB_FIRST    = 1
) (
   input  logic           i_clk,
   input  logic           i_clr_n,
   uart_piso_tx_if.slave  io_tx
);
   localparam int BW = cnt_w(DATA_W);

   generate
      if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
         $error("uart_piso_tx: DATA_W must be in 5..9");
      end
      if (CLKS_PER_BIT < 2) begin : g_bad_clks
         $error("uart_piso_tx: CLKS_PER_BIT must be >= 2");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
         $error("uart_piso_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   tx_state_e         r_state;
   tx_state_e         w_state_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_buf;
   logic              r_buf_full;
   logic              r_par;
   logic [BW-1:0]     r_bit_cnt;
   logic              r_ready;
   logic              r_serial;
   logic              r_busy;
   logic              r_done;

   logic              w_bit_end;
   logic              w_accept;
   logic              w_last_data;
   logic              w_last_stop;
   logic              w_frame_end;
   logic              w_load;
   logic              w_load_from_buf;
   logic              w_to_buf;
   logic              w_line;
   logic [DATA_W-1:0] w_load_word;
   logic [DATA_W-1:0] w_load_ord;

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .i_clk     (i_clk),
      .i_clr_n   (i_clr_n),
      .i_en      (r_state != IDLE),
      .i_restart (w_load),
      .o_bit_end (w_bit_end)
   );

   assign w_accept    = io_tx.tx_valid && r_ready;
   assign w_last_data = (r_bit_cnt == BW'(DATA_W - 1));
   assign w_last_stop = (r_bit_cnt == BW'(STOP_BITS - 1));
   assign w_frame_end = (r_state == STOP) && w_bit_end && w_last_stop;
   // An accept can only land in the buffer when it is not consumed by a direct load.
   assign w_to_buf    = w_accept && !w_load;

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_load          = 1'b0;
      w_load_from_buf = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = START;
               w_load      = 1'b1;
            end
         end
         START: begin
            if (w_bit_end) w_state_nxt = DATA;
         end
         DATA: begin
            if (w_bit_end && w_last_data) w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
         end
         PARITY: begin
            if (w_bit_end) w_state_nxt = STOP;
         end
         STOP: begin
            if (w_frame_end) begin
               if (r_buf_full) begin
                  w_state_nxt     = START;
                  w_load          = 1'b1;
                  w_load_from_buf = 1'b1;
               end else if (w_accept) begin
                  w_state_nxt = START;
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Words are stored in transmit order so the shifter always sends bit 0.
   always_comb begin
      w_load_word = w_load_from_buf ? r_buf : io_tx.tx_data;
      w_load_ord  = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_load_ord[i] = (LSB_FIRST != 0) ? w_load_word[i] : w_load_word[DATA_W-1-i];
      end
   end

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_shift    <= '0;
         r_buf      <= '0;
         r_buf_full <= 1'b0;
         r_par      <= 1'b0;
         r_bit_cnt  <= '0;
      end else begin
         if (w_load) begin
            r_shift   <= w_load_ord;
            r_par     <= (^w_load_word) ^ (PARITY_ODD != 0);
            r_bit_cnt <= '0;
         end else if (w_bit_end) begin
            if (r_state == DATA) begin
               r_shift   <= r_shift >> 1;
               r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + 1'b1;
            end else if (r_state == STOP) begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
         end
         if (w_load_from_buf) begin
            r_buf_full <= 1'b0;
         end else if (w_to_buf) begin
            r_buf      <= io_tx.tx_data;
            r_buf_full <= 1'b1;
         end
      end
   end

   always_comb begin
      w_line = 1'b1;
      case (r_state)
         START:   w_line = 1'b0;
         DATA:    w_line = r_shift[0];
         PARITY:  w_line = r_par;
         default: w_line = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_serial <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ready  <= 1'b0;
      end else begin
         r_serial <= w_line;
         r_busy   <= (r_state != IDLE);
         r_done   <= w_frame_end;
         r_ready  <= w_load_from_buf || (!w_to_buf && !r_buf_full);
      end
   end

   assign io_tx.tx_ready   = r_ready;
   assign io_tx.serial_out = r_serial;
   assign io_tx.tx_busy    = r_busy;
   assign io_tx.tx_done    = r_done;

endmodule

// File: doc/uart_piso_tx.md
Name: uart_piso_tx

Overview:
Parametrised parallel-in/serial-out UART transmitter. It serialises a DATA_W-bit word into an asynchronous frame: start bit, data, optional parity, then 1 or 2 stop bits. It has an internal baud divider and a one-entry holding buffer, so frames can be sent back-to-back. It sits between the byte-producing logic (valid/ready handshake) and the TX pin.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, CLK cycles per serial bit; must be >= 2.
STOP_BITS, 1, number of stop bits; 1 or 2.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
LSB_FIRST, 1, 1 = D[0] is sent first, 0 = D[DATA_W-1] is sent first.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
CLR_N  in  1  asynchronous, active-low reset.
TX_DATA  in  DATA_W  parallel word to send.
TX_VALID  in  1  TX_DATA is valid.
TX_READY  out  1  block can accept a word; a word transfers when TX_VALID & TX_READY at a rising edge.
SERIAL_OUT  out  1  serial line; idles high.
TX_BUSY  out  1  a frame is being shifted out.
TX_DONE  out  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (CLR_N low, asynchronous):
  - Outputs: SERIAL_OUT=1, TX_BUSY=0, TX_DONE=0, TX_READY=0.
  - Internal: FSM=IDLE, baud counter=0, holding buffer empty.
  - TX_READY goes to 1 on the first rising edge after CLR_N deasserts.
- Reset mid-frame aborts the frame immediately: the line returns high with no glitch low, and the buffered word is discarded.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after one bit time.
  - DATA -> PARITY (if PARITY_EN) or STOP after DATA_W bit times.
  - PARITY -> STOP after one bit time.
  - STOP -> START if the holding buffer is full or an accept occurs in the same cycle; otherwise STOP -> IDLE.
- Bit timing:
  - Baud counter runs 0..CLKS_PER_BIT-1 within each bit and wraps to 0 at each bit boundary.
  - Every bit is exactly CLKS_PER_BIT cycles.
  - Frame length is (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Latency: SERIAL_OUT and all outputs are registered. SERIAL_OUT goes low on the edge after the accept edge.
- Line values: start bit = 0; stop bit(s) = 1; parity = XOR of the data bits, inverted when PARITY_ODD=1.
- Data capture: the word is captured into the shift register at load time. Later changes on TX_DATA have no effect on a frame in flight.
- Holding buffer and TX_READY:
  - TX_READY is registered and equals "holding buffer empty".
  - Accept while IDLE: word goes straight to the shift register.
  - Accept while busy: word goes to the holding buffer, and TX_READY falls on the next edge.
- End of frame (last cycle of the final stop bit):
  - If the holding buffer is full, its word loads into the shift register, the next start bit follows with zero idle cycles, the buffer empties, and TX_READY rises on the next edge.
  - If the buffer is empty and an accept occurs in that same cycle, the word loads directly into the shift register, also back-to-back.
- TX_BUSY = (state != IDLE), registered. It stays high across back-to-back frames.
- TX_DONE pulses once per frame, including the first of two back-to-back frames.
- TX_VALID while TX_READY=0: no transfer. The producer holds TX_DATA/TX_VALID until it sees TX_READY.
- Illegal parameters are rejected at elaboration: DATA_W outside 5..9, CLKS_PER_BIT < 2, STOP_BITS not in {1,2}.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - localparam function frame_bits(DATA_W, PARITY_EN, STOP_BITS);
  - bit-counter width function clog2-based.
- One natural sub-module, uart_baud_cnt:
  - divides CLK by CLKS_PER_BIT;
  - emits a bit_end strobe;
  - synchronous restart input used at frame load;
  - same CLK/CLR_N.

Test Plan:
1. DATA_W=8, CLKS_PER_BIT=4, no parity, 1 stop; send 0x0B -> SERIAL_OUT bits 0,1,1,0,1,0,0,0,0,1, each held 4 cycles; frame = 40 cycles; TX_DONE pulses at cycle 40; then idle high, TX_BUSY=0.
2. Same config with PARITY_EN=1: 0x0B even -> parity bit 1, frame 44 cycles; PARITY_ODD=1 -> parity bit 0.
3. Back-to-back: accept 0x55, then 0xA3 two cycles later -> TX_READY low until frame 1 ends; frame 2 start bit immediately follows the stop bit with no idle gap; two TX_DONE pulses 40 cycles apart.
4. STOP_BITS=2, LSB_FIRST=0, send 0x80 -> bits 0,1,0,0,0,0,0,0,0,1,1; stop phase 8 cycles.
5. Assert CLR_N low at cycle 15 mid-frame -> SERIAL_OUT=1, TX_BUSY=0, TX_READY=0 immediately; buffered word discarded; a new word after release sends cleanly.
6. TX_VALID held with changing TX_DATA while TX_READY=0 -> no extra frames; only the accepted values are sent.
